// File: rtl/clock_mode_ctrl_if.sv
// rtl/clock_mode_ctrl_if.sv - button inputs and display outputs of the clock/mode controller
//
// Purpose: groups the debounced buttons, the seven segment codes, the mode
//          and the seconds strobe into one bundle.
// Signals:
//    btn_mode, btn_inc       debounced button levels (controller input)
//    h1 h2 m1 m2 s1 s2 ap    active-low segment codes, bit6 = a .. bit0 = g
//    mode                    0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC
//    sec_tick                one-cycle pulse per prescaler wrap
// Modports: master drives the buttons, slave is the controller.

interface clock_mode_ctrl_if;
   logic       btn_mode;
   logic       btn_inc;
   logic [6:0] h1;
   logic [6:0] h2;
   logic [6:0] m1;
   logic [6:0] m2;
   logic [6:0] s1;
   logic [6:0] s2;
   logic [6:0] ap;
   logic [1:0] mode;
   logic       sec_tick;

   modport master (
      output btn_mode, btn_inc,
      input  h1, h2, m1, m2, s1, s2, ap, mode, sec_tick
   );

   modport slave (
      input  btn_mode, btn_inc,
      output h1, h2, m1, m2, s1, s2, ap, mode, sec_tick
   );
endinterface

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - 12-hour timekeeping, RUN/SET mode FSM and 7-segment encoding
//
// Purpose: keeps hh:mm:ss AM/PM from an internal 1 Hz prescaler, lets the user
//          set hours/minutes/clear seconds with two buttons, and registers the
//          seven segment codes (with blinking of the field being edited).
// Ports:
//    CLK        system clock
//    RST_BTN    synchronous active-high reset
//    bus        clock_mode_ctrl_if.slave (buttons in; segments, mode, sec_tick out)
// Parameters:
//    TICK_DIV   CLK cycles per second
//    CNT_W      prescaler width, 2**CNT_W >= TICK_DIV

module clock_mode_ctrl #(
   parameter int TICK_DIV = 100000000,
   parameter int CNT_W    = 27
) (
   input logic              CLK,
   input logic              RST_BTN,
   clock_mode_ctrl_if.slave bus
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_SET_HR  = 2'd1;
   localparam logic [1:0] ST_SET_MIN = 2'd2;
   localparam logic [1:0] ST_SET_SEC = 2'd3;

   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] PRESC_HALF = CNT_W'(TICK_DIV / 2);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_P     = 7'b0011000;

   logic [CNT_W-1:0] presc;
   logic [1:0]       state;
   logic [3:0]       hours;
   logic [5:0]       minutes;
   logic [5:0]       seconds;
   logic             pm;
   logic             btn_mode_q;
   logic             btn_inc_q;

   logic mode_edge, inc_edge, inc_event, wrap, blank_phase;
   logic [6:0] h1_n, h2_n, m1_n, m2_n, s1_n, s2_n, ap_n;

   function automatic logic [6:0] seg_digit(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return SEG_BLANK;
      endcase
   endfunction

   // 12 -> 1 -> ... -> 11 -> 12 ; the AM/PM flip happens on the 11 -> 12 step
   function automatic logic [3:0] hour_next(input logic [3:0] h);
      return (h == 4'd12) ? 4'd1 : h + 4'd1;
   endfunction

   assign mode_edge   = bus.btn_mode & ~btn_mode_q;
   assign inc_edge    = bus.btn_inc & ~btn_inc_q;
   assign inc_event   = inc_edge & ~mode_edge;   // mode wins a simultaneous press
   assign wrap        = (presc == PRESC_LAST);
   assign blank_phase = (presc >= PRESC_HALF);

   always_comb begin
      h1_n = (hours >= 4'd10) ? seg_digit(4'd1) : SEG_BLANK;
      h2_n = seg_digit((hours >= 4'd10) ? hours - 4'd10 : hours);
      m1_n = seg_digit(4'(minutes / 6'd10));
      m2_n = seg_digit(4'(minutes % 6'd10));
      s1_n = seg_digit(4'(seconds / 6'd10));
      s2_n = seg_digit(4'(seconds % 6'd10));
      ap_n = pm ? SEG_P : SEG_A;
      if (blank_phase) begin
         case (state)
            ST_SET_HR: begin
               h1_n = SEG_BLANK;
               h2_n = SEG_BLANK;
               ap_n = SEG_BLANK;
            end
            ST_SET_MIN: begin
               m1_n = SEG_BLANK;
               m2_n = SEG_BLANK;
            end
            ST_SET_SEC: begin
               s1_n = SEG_BLANK;
               s2_n = SEG_BLANK;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST_BTN) begin
         presc        <= '0;
         state        <= ST_RUN;
         hours        <= 4'd12;
         minutes      <= 6'd0;
         seconds      <= 6'd0;
         pm           <= 1'b0;
         btn_mode_q   <= 1'b0;
         btn_inc_q    <= 1'b0;
         bus.sec_tick <= 1'b0;
         bus.mode     <= ST_RUN;
         bus.h1       <= seg_digit(4'd1);
         bus.h2       <= seg_digit(4'd2);
         bus.m1       <= seg_digit(4'd0);
         bus.m2       <= seg_digit(4'd0);
         bus.s1       <= seg_digit(4'd0);
         bus.s2       <= seg_digit(4'd0);
         bus.ap       <= SEG_A;
      end else begin
         btn_mode_q   <= bus.btn_mode;
         btn_inc_q    <= bus.btn_inc;
         bus.sec_tick <= wrap;

         // Leaving SET_SEC or clearing seconds restarts the second from zero
         if ((state == ST_SET_SEC) && (mode_edge || inc_edge))
            presc <= '0;
         else if (wrap)
            presc <= '0;
         else
            presc <= presc + CNT_W'(1);

         // SET_SEC + 1 wraps back to RUN
         if (mode_edge)
            state <= state + 2'd1;

         if (state == ST_RUN) begin
            if (wrap) begin
               if (seconds == 6'd59) begin
                  seconds <= 6'd0;
                  if (minutes == 6'd59) begin
                     minutes <= 6'd0;
                     hours   <= hour_next(hours);
                     if (hours == 4'd11)
                        pm <= ~pm;
                  end else begin
                     minutes <= minutes + 6'd1;
                  end
               end else begin
                  seconds <= seconds + 6'd1;
               end
            end
         end else if (inc_event) begin
            case (state)
               ST_SET_HR: begin
                  hours <= hour_next(hours);
                  if (hours == 4'd11)
                     pm <= ~pm;
               end
               ST_SET_MIN: minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
               ST_SET_SEC: seconds <= 6'd0;
               default: ;
            endcase
         end

         bus.mode <= state;
         bus.h1   <= h1_n;
         bus.h2   <= h2_n;
         bus.m1   <= m1_n;
         bus.m2   <= m2_n;
         bus.s1   <= s1_n;
         bus.s2   <= s2_n;
         bus.ap   <= ap_n;
      end
   end

endmodule
